// File: rtl/sr_input_conditioner.sv
// Synchronises, debounces and arbitrates two raw set/clear request lines into exclusive one-cycle s/r pulses.
// Optional saturating conflict counter enabled by defining SR_CONFLICT_CNT_EN.
module sr_input_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_stable,
    output logic clr_stable
`ifdef SR_CONFLICT_CNT_EN
    ,
    output logic [7:0] conflict_cnt
`endif
);

    localparam int unsigned NCH = 2;
    localparam int unsigned CH_SET = 0;
    localparam int unsigned CH_CLR = 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HELD = 2'd1,
        CLR_HELD = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    logic [NCH-1:0]            r_sync1;
    logic [NCH-1:0]            r_sync2;
    logic [NCH-1:0]            r_stable;
    logic [NCH-1:0]            r_stable_d;
    logic [NCH-1:0][CNT_W-1:0] r_db_cnt;
    logic [NCH-1:0]            w_rise;

    state_t r_state;
    logic   r_s;
    logic   r_r;
    logic   r_conflict;

    // Two-flop synchroniser and per-channel debounce; a new level must persist DB_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1    <= {clr_in, set_in};
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    // Arbitration: only rising stable edges emit pulses, and s/r are mutually exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise[CH_SET] && w_rise[CH_CLR]) begin
                        r_conflict <= 1'b1;
                        r_state    <= LOCKED;
                    end else if (w_rise[CH_SET]) begin
                        r_s     <= 1'b1;
                        r_state <= SET_HELD;
                    end else if (w_rise[CH_CLR]) begin
                        r_r     <= 1'b1;
                        r_state <= CLR_HELD;
                    end
                end
                SET_HELD: begin
                    if (w_rise[CH_CLR]) begin
                        r_conflict <= 1'b1;
                        r_state    <= LOCKED;
                    end else if (!r_stable[CH_SET]) begin
                        r_state <= IDLE;
                    end
                end
                CLR_HELD: begin
                    if (w_rise[CH_SET]) begin
                        r_conflict <= 1'b1;
                        r_state    <= LOCKED;
                    end else if (!r_stable[CH_CLR]) begin
                        r_state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (!r_stable[CH_SET] && !r_stable[CH_CLR]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s          = r_s;
    assign r          = r_r;
    assign conflict   = r_conflict;
    assign set_stable = r_stable[CH_SET];
    assign clr_stable = r_stable[CH_CLR];

`ifdef SR_CONFLICT_CNT_EN
    localparam logic [7:0] CCNT_MAX = 8'hFF;

    logic [7:0] r_conflict_cnt;

    // Saturating count of suppressed requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (r_conflict && (r_conflict_cnt != CCNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Scoreboard bench for sr_input_conditioner: expected pulses are queued with their due cycle when
// stimulus is driven, and a monitor pops and compares them whenever s/r/conflict fires.
module tb_sr_input_conditioner;

    localparam int unsigned DB  = 4;
    localparam int          LAT = int'(DB) + 3;  // drive negedge -> pulse visible at negedge
    localparam int          STB = int'(DB) + 2;  // drive negedge -> stable level change

    localparam int EV_S = 0;
    localparam int EV_R = 1;
    localparam int EV_C = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;
    logic s, r, conflict, set_stable, clr_stable;
`ifdef SR_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
    int         n_conflicts = 0;
`endif

    int  vectors = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t exp_q[$];

    sr_input_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .set_in     (set_in),
        .clr_in     (clr_in),
        .s          (s),
        .r          (r),
        .conflict   (conflict),
        .set_stable (set_stable),
        .clr_stable (clr_stable)
`ifdef SR_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        int  got;
        ev_t e;
        if ((s === 1'b1) || (r === 1'b1) || (conflict === 1'b1)) begin
            got = (s === 1'b1) ? EV_S : ((r === 1'b1) ? EV_R : EV_C);
            vectors++;
            if ($countones({s, r, conflict}) > 1) begin
                errors++;
                $display("FAIL exclusive: cyc %0d s=%b r=%b conflict=%b, required at most one high",
                         cyc, s, r, conflict);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc %0d kind %0d, required no pulse", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if ((e.kind !== got) || (e.at !== cyc)) begin
                    errors++;
                    $display("FAIL pulse: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                             got, cyc, e.kind, e.at);
                end
            end
        end
    end

    task automatic expect_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.at   = cyc + LAT;
        exp_q.push_back(e);
`ifdef SR_CONFLICT_CNT_EN
        if (kind == EV_C) n_conflicts++;
`endif
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({s, r, conflict, set_stable, clr_stable} !== 5'b0) begin
            errors++;
            $display("FAIL %s: cyc %0d {s,r,conflict,set_stable,clr_stable}=%b, required 00000",
                     name, cyc, {s, r, conflict, set_stable, clr_stable});
        end
`ifdef SR_CONFLICT_CNT_EN
        vectors++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s_cnt: conflict_cnt=%0d, required 0", name, conflict_cnt);
        end
`endif
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check_all_zero("reset_outputs");
            @(negedge clk);
        end
        reset = 1'b0;
`ifdef SR_CONFLICT_CNT_EN
        n_conflicts = 0;
`endif
    endtask

    task automatic test_reset;
        @(negedge clk);
        do_reset(2);
    endtask

    task automatic test_single_set;
        int k, j;
        @(negedge clk);
        set_in = 1'b1;
        k = cyc;
        expect_ev(EV_S);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (set_stable !== (cyc >= k + STB)) begin
                errors++;
                $display("FAIL set_stable_rise: cyc %0d set_stable=%b, required %b",
                         cyc, set_stable, (cyc >= k + STB));
            end
        end
        set_in = 1'b0;
        j = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (set_stable !== (cyc < j + STB)) begin
                errors++;
                $display("FAIL set_stable_fall: cyc %0d set_stable=%b, required %b",
                         cyc, set_stable, (cyc < j + STB));
            end
        end
    endtask

    task automatic test_bounce;
        int pattern[7] = '{1, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            set_in = pattern[i][0];
            @(negedge clk);
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            vectors++;
            if (set_stable !== 1'b0) begin
                errors++;
                $display("FAIL bounce: cyc %0d set_stable=%b, required 0", cyc, set_stable);
            end
        end
    endtask

    task automatic test_simultaneous;
        set_in = 1'b1;
        clr_in = 1'b1;
        expect_ev(EV_C);
        wait_cyc(12);
        set_in = 1'b0;
        wait_cyc(12);
        set_in = 1'b1;
        wait_cyc(12);
        set_in = 1'b0;
        clr_in = 1'b0;
        wait_cyc(14);
        set_in = 1'b1;
        expect_ev(EV_S);
        wait_cyc(12);
        set_in = 1'b0;
        wait_cyc(14);
    endtask

    task automatic test_overlap;
        set_in = 1'b1;
        expect_ev(EV_S);
        wait_cyc(12);
        clr_in = 1'b1;
        expect_ev(EV_C);
        wait_cyc(12);
        set_in = 1'b0;
        clr_in = 1'b0;
        wait_cyc(14);
        clr_in = 1'b1;
        expect_ev(EV_R);
        wait_cyc(12);
        clr_in = 1'b0;
        wait_cyc(14);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 2; n++) begin
            set_in = 1'b1;
            expect_ev(EV_S);
            wait_cyc(8);
            set_in = 1'b0;
            wait_cyc(10);
        end
        wait_cyc(6);
    endtask

    task automatic test_reset_mid_press;
        int k;
        set_in = 1'b1;
        expect_ev(EV_S);
        wait_cyc(12);
        do_reset(3);
        k = cyc;
        expect_ev(EV_S);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (set_stable !== (cyc >= k + STB)) begin
                errors++;
                $display("FAIL redebounce: cyc %0d set_stable=%b, required %b",
                         cyc, set_stable, (cyc >= k + STB));
            end
        end
        set_in = 1'b0;
        wait_cyc(14);
    endtask

    task automatic test_abort;
        set_in = 1'b1;
        wait_cyc(STB);
        set_in = 1'b0;
        do_reset(3);
        wait_cyc(14);
    endtask

`ifdef SR_CONFLICT_CNT_EN
    task automatic test_conflict_cnt;
        for (int n = 0; n < 300; n++) begin
            set_in = 1'b1;
            clr_in = 1'b1;
            expect_ev(EV_C);
            wait_cyc(10);
            set_in = 1'b0;
            clr_in = 1'b0;
            wait_cyc(12);
            if ((n == 99) || (n == 299)) begin
                vectors++;
                if (conflict_cnt !== 8'((n_conflicts > 255) ? 255 : n_conflicts)) begin
                    errors++;
                    $display("FAIL conflict_cnt: after %0d events got %0d, required %0d",
                             n_conflicts, conflict_cnt, (n_conflicts > 255) ? 255 : n_conflicts);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_set();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_back_to_back();
        test_reset_mid_press();
        test_abort();
`ifdef SR_CONFLICT_CNT_EN
        test_conflict_cnt();
`endif
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            errors++;
            $display("FAIL missing_pulse: kind %0d due at cyc %0d never seen", e.kind, e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Front-end stage feeding the SR flip-flop's `s`/`r` inputs from two raw, asynchronous, bouncy request lines (set and clear). Each line is synchronised and debounced. Each debounced press becomes a single-cycle `s` or `r` pulse. Simultaneous or overlapping requests are arbitrated so that `s` and `r` are never high together, which keeps the downstream flip-flop out of its invalid state.

## Interface
- `DB_CYCLES`, 4: consecutive synchronised cycles a new level must persist before it is accepted; legal range 1 to 2^CNT_W-1.
- `CNT_W`, 8: width of each debounce counter.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `set_in`  in  1  raw set request, asynchronous to `clk`.
- `clr_in`  in  1  raw clear request, asynchronous to `clk`.
- `s`  out  1  one-cycle set pulse to the SR flip-flop.
- `r`  out  1  one-cycle reset pulse to the SR flip-flop.
- `conflict`  out  1  one-cycle pulse marking a suppressed request.
- `set_stable`  out  1  debounced level of `set_in`.
- `clr_stable`  out  1  debounced level of `clr_in`.
- `conflict_cnt`  out  8  saturating conflict count; present only under `SR_CONFLICT_CNT_EN`.

## Operation
- **Reset values:** all outputs 0, synchronisers 0, debounce counters 0, FSM in IDLE.
- **Synchroniser:** each input passes through a two-flop synchroniser (`sync1`, `sync2`).
- **Debounce, per channel:**
  - If `sync2 == stable`, the counter is cleared to 0.
  - Otherwise, if the counter equals DB_CYCLES-1, `stable <= sync2` and the counter is cleared.
  - Otherwise the counter increments.
  - A glitch shorter than DB_CYCLES cycles therefore never changes `stable`.
- **Edge detect:** `rise_x = stable_x & ~stable_x_d`, where `stable_x_d` is `stable_x` delayed one cycle.
- **FSM state IDLE:**
  - `rise_set` only: `s`=1 next cycle, go to SET_HELD.
  - `rise_clr` only: `r`=1 next cycle, go to CLR_HELD.
  - Both in the same cycle: `conflict`=1, go to LOCKED.
- **FSM state SET_HELD:**
  - `rise_clr`: `conflict`=1 with no `r`, go to LOCKED.
  - Else if `set_stable`=0: go to IDLE.
- **FSM state CLR_HELD:** mirror of SET_HELD (`rise_set` gives `conflict`, no `s`).
- **FSM state LOCKED:** no `s`/`r` output; go to IDLE only when `set_stable`=0 and `clr_stable`=0.
- **Invariants:**
  - `s & r` is never 1.
  - `s`, `r` and `conflict` are each high for at most one cycle per accepted edge.
- **Releases:** only return the FSM toward IDLE; they never generate `s` or `r`.

## Timing
- **Press latency:** `set_in` high before edge N and held. `sync2`=1 after edge N+1, `set_stable`=1 after edge N+1+DB_CYCLES, `s`=1 for exactly the cycle after edge N+2+DB_CYCLES. Same for `clr_in`/`r`.
- **Release latency:** `set_stable` falls DB_CYCLES+1 edges after the low is first sampled. The FSM leaves SET_HELD on the following edge.
- **Back-to-back presses:** a second press on the same line needs a full release and re-press. Minimum press-to-press spacing is 2·(DB_CYCLES+1)+1 cycles.
- **Same-edge stable rise:** both stable levels rising on the same edge count as simultaneous (conflict).
- **Reset mid-operation:** outputs drop to 0 immediately (asynchronously). After `reset` deasserts, an input still held high is re-debounced from 0 and produces a fresh pulse at the normal latency.
- **Pulse aborted by reset:** a pending `s`/`r` pulse is lost. No partial pulse is emitted after reset.

## Configuration
- **`SR_CONFLICT_CNT_EN` defined:**
  - Port `conflict_cnt` exists and resets to 0.
  - It increments on every `conflict` pulse and saturates at 255.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single set press:** DB_CYCLES=4, reset 2 cycles, then `set_in` high for 20 cycles → `s`=1 for exactly one cycle, 6 edges after the first sampling edge; `r`=0 throughout; `set_stable` follows.
- **Bounce rejection:** `set_in` toggled 1-0-1 with 2-cycle segments, then held low → `set_stable` stays 0; no `s`.
- **Simultaneous press:** `set_in` and `clr_in` rise together → `conflict`=1 for one cycle; `s`=`r`=0; FSM returns to IDLE only after both are released.
- **Overlap:** set held (`s` pulse seen), then `clr_in` pressed → `conflict` pulse, no `r`. Release both, then press `clr_in` alone → one `r` pulse.
- **Reset mid-press:** `set_in` held, `reset` asserted for 3 cycles after `s` → outputs 0 during reset; one new `s` pulse DB_CYCLES+3 edges after release.
- **Conflict counter (with `SR_CONFLICT_CNT_EN`):** 300 conflict events → `conflict_cnt`=255.
